exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Exception/interrupt sequencing stage that sits beside the single-cycle LEGv8 datapath's controller.
- Upstream: synchronises and latches the raw external interrupt line, and presents a clean, masked ExtIRQ level to the controller.
- Downstream: consumes the controller's Exc/EStatus/ERet/ExtIAck outputs, saves exception state (ELR, ESR), drives the PC-redirect to the vector or return address, and tracks handler mode.

Parameters:
N, 64, datapath/PC width
VECTOR_ADDR, 64'h00000000000000D8, exception vector address
CNT_W, 8, width of saturating exception counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
IrqRaw  in  1  raw external interrupt line, asynchronous to clk, level
PC  in  N  PC of instruction currently executing
Exc  in  1  exception request from controller (illegal opcode or ExtIRQ)
EStatus  in  4  cause code from controller: 0010 illegal, 0001 ext IRQ
ERet  in  1  ERET instruction executing
ExtIAck  in  1  interrupt acknowledge from controller
ExtIRQ  out  1  masked pending-interrupt request to controller
ExcAck  out  1  exception accepted this cycle
ExcRedirect  out  1  override next-PC mux this cycle
ExcPC  out  N  next PC when ExcRedirect=1
ELR  out  N  exception link register
ESR  out  4  exception syndrome register
InHandler  out  1  handler mode flag
ExcCount  out  CNT_W  saturating count of accepted exceptions

Behaviour:
- All flops reset asynchronously when reset=0.
- Reset values:
  - state=RUN, ELR=0, ESR=0, sync flops=0, pending=0, ExcCount=0.
  - Combinational outputs evaluate from the reset state: ExtIRQ=0, ExcAck=0, ExcRedirect=0, ExcPC=VECTOR_ADDR, InHandler=0.
- IRQ front end:
  - Two-flop synchroniser on IrqRaw, then a third flop for rising-edge detection.
  - A detected rising edge sets pending on the following clk edge.
  - pending clears on any edge where ExtIAck=1.
  - Set and clear in the same cycle: set wins, pending stays 1.
  - Latency: IrqRaw 0->1 to ExtIRQ=1 is exactly 3 clk edges when in RUN.
- Masking: ExtIRQ = pending & (state==RUN). Pending is retained, not lost, while in HANDLER.
- FSM states: RUN, HANDLER. InHandler = (state==HANDLER).
- RUN & Exc=1 (combinational outputs, same cycle):
  - ExcAck=1, ExcRedirect=1, ExcPC=VECTOR_ADDR.
- RUN & Exc=1 (next edge):
  - ELR<=PC, ESR<=EStatus, ExcCount<=ExcCount+1 (saturates at all-ones), state<=HANDLER.
- RUN & ERet=1 & Exc=0: ignored. No redirect, no state change.
- RUN with Exc and ERet both 1: Exc wins, ERet ignored.
- HANDLER & ERet=1 & Exc=0:
  - Same cycle: ExcRedirect=1, ExcPC=ELR.
  - Next edge: state<=RUN. ELR and ESR hold their values.
- HANDLER & Exc=1 (double fault):
  - Same cycle: ExcAck=0, ExcRedirect=1, ExcPC=VECTOR_ADDR.
  - Next edge: ESR[3]<=1 (sticky); ESR[2:0] and ELR unchanged; ExcCount unchanged; state stays HANDLER.
  - The ERet is ignored if it coincides.
- ESR[3] clears only on reset, or when a new exception is accepted from RUN (ESR<=EStatus, whose bit 3 is 0).
- ExcCount is counted only on acceptance from RUN.
- Reset asserted mid-handler: immediately forces RUN and clears all state. pending is lost.
- No combinational path exists from ExtIAck to ExtIRQ; pending is registered.
- When ExcRedirect=0, ExcPC is don't-care and driven to VECTOR_ADDR.

Test Plan:
- Reset: hold reset=0 with IrqRaw=1 and Exc=1 -> all outputs at reset values, ExcCount=0. Release reset -> no ExcAck until Exc is sampled in RUN.
- Illegal opcode: state RUN, PC=0x40, Exc=1, EStatus=0010 for one cycle -> same cycle ExcAck=1, ExcRedirect=1, ExcPC=0xD8. Next cycle ELR=0x40, ESR=0010, InHandler=1, ExcCount=1.
- Return: from HANDLER with ELR=0x40, pulse ERet -> ExcRedirect=1, ExcPC=0x40 that cycle. Next cycle InHandler=0.
- IRQ path:
  - Raise IrqRaw at cycle 0 -> ExtIRQ=1 after 3 edges.
  - Drive Exc=1, EStatus=0001, ExtIAck=1 with PC=0x100 -> pending clears, ELR=0x100, ESR=0001.
  - Second IrqRaw edge while in HANDLER -> ExtIRQ held 0 until ERet, then rises the cycle after return.
- Double fault: in HANDLER with ESR=0001, ELR=0x100, apply Exc=1, EStatus=0010 -> ExcAck=0, ExcPC=0xD8, ESR=1001, ELR=0x100, ExcCount unchanged.
- Saturation and corners:
  - Accept 260 exceptions (Exc then ERet pairs) -> ExcCount stops at 255.
  - ERet in RUN -> no redirect.
  - Pending set and ExtIAck in the same cycle -> pending stays 1.

Source files
------------

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception/interrupt sequencing beside the LEGv8 controller
// IRQ synchroniser and pending latch, RUN/HANDLER FSM, ELR/ESR save and PC redirect.
module exception_ctrl #(
   parameter int               N           = 64,
   parameter logic [N-1:0]     VECTOR_ADDR = 64'h00000000000000D8,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IrqRaw,
   input  logic [N-1:0]     PC,
   input  logic             Exc,
   input  logic [3:0]       EStatus,
   input  logic             ERet,
   input  logic             ExtIAck,
   output logic             ExtIRQ,
   output logic             ExcAck,
   output logic             ExcRedirect,
   output logic [N-1:0]     ExcPC,
   output logic [N-1:0]     ELR,
   output logic [3:0]       ESR,
   output logic             InHandler,
   output logic [CNT_W-1:0] ExcCount
);

   typedef enum logic {RUN, HANDLER} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     elr_q, elr_d;
   logic [3:0]       esr_q, esr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             sync3_q, sync3_d;
   logic             pending_q, pending_d;
   logic             irq_rise;

   // sync1/sync2 resolve metastability; sync3 holds the previous clean sample
   always_comb begin
      sync1_d   = IrqRaw;
      sync2_d   = sync1_q;
      sync3_d   = sync2_q;
      irq_rise  = sync2_q & ~sync3_q;
      pending_d = irq_rise | (pending_q & ~ExtIAck);
   end

   always_comb begin
      state_d     = state_q;
      elr_d       = elr_q;
      esr_d       = esr_q;
      cnt_d       = cnt_q;
      ExcAck      = 1'b0;
      ExcRedirect = 1'b0;
      ExcPC       = VECTOR_ADDR;
      if (reset) begin
         case (state_q)
            RUN: begin
               if (Exc) begin
                  ExcAck      = 1'b1;
                  ExcRedirect = 1'b1;
                  elr_d       = PC;
                  esr_d       = EStatus;
                  cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                  state_d     = HANDLER;
               end
            end
            HANDLER: begin
               // a fault inside the handler only marks the syndrome; the return address is kept
               if (Exc) begin
                  ExcRedirect = 1'b1;
                  esr_d[3]    = 1'b1;
               end else if (ERet) begin
                  ExcRedirect = 1'b1;
                  ExcPC       = elr_q;
                  state_d     = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         elr_q     <= '0;
         esr_q     <= '0;
         cnt_q     <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         elr_q     <= elr_d;
         esr_q     <= esr_d;
         cnt_q     <= cnt_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         pending_q <= pending_d;
      end
   end

   assign ExtIRQ    = pending_q & (state_q == RUN);
   assign InHandler = (state_q == HANDLER);
   assign ELR       = elr_q;
   assign ESR       = esr_q;
   assign ExcCount  = cnt_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl
// Directed scenarios followed by random traffic, compared against a behavioural model.
module tb_exception_ctrl;

   localparam logic [63:0] VEC = 64'h00000000000000D8;

   logic        clk;
   logic        reset;
   logic        IrqRaw;
   logic [63:0] PC;
   logic        Exc;
   logic [3:0]  EStatus;
   logic        ERet;
   logic        ExtIAck;
   logic        ExtIRQ;
   logic        ExcAck;
   logic        ExcRedirect;
   logic [63:0] ExcPC;
   logic [63:0] ELR;
   logic [3:0]  ESR;
   logic        InHandler;
   logic [7:0]  ExcCount;

   exception_ctrl dut (
      .clk(clk), .reset(reset), .IrqRaw(IrqRaw), .PC(PC), .Exc(Exc),
      .EStatus(EStatus), .ERet(ERet), .ExtIAck(ExtIAck), .ExtIRQ(ExtIRQ),
      .ExcAck(ExcAck), .ExcRedirect(ExcRedirect), .ExcPC(ExcPC), .ELR(ELR),
      .ESR(ESR), .InHandler(InHandler), .ExcCount(ExcCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: handler flag, saved state, counter, and raw IRQ samples per edge
   bit          m_hand;
   logic [63:0] m_elr;
   logic [3:0]  m_esr;
   int          m_cnt;
   bit          m_pend;
   bit          m_samp[$];

   task automatic model_reset();
      m_hand = 0;
      m_elr  = '0;
      m_esr  = '0;
      m_cnt  = 0;
      m_pend = 0;
      m_samp = {0, 0, 0};
   endtask

   // one clock: drive at posedge+1, compare at negedge, advance model at posedge
   task automatic cycle(input bit exc, input logic [3:0] es, input bit eret,
                        input bit ack, input bit irq, input logic [63:0] pc);
      bit seen_edge;
      Exc = exc; EStatus = es; ERet = eret; ExtIAck = ack; IrqRaw = irq; PC = pc;
      @(negedge clk);
      check("ExtIRQ", 64'(ExtIRQ), 64'(m_pend && !m_hand));
      check("ExcAck", 64'(ExcAck), 64'(exc && !m_hand));
      check("ExcRedirect", 64'(ExcRedirect), 64'(exc || (m_hand && eret)));
      check("ExcPC", ExcPC, (m_hand && eret && !exc) ? m_elr : VEC);
      check("ELR", ELR, m_elr);
      check("ESR", 64'(ESR), 64'(m_esr));
      check("InHandler", 64'(InHandler), 64'(m_hand));
      check("ExcCount", 64'(ExcCount), 64'(m_cnt));
      @(posedge clk);
      // an edge is visible once a sample two edges old is 1 and the one before it was 0
      seen_edge = m_samp[m_samp.size()-2] && !m_samp[m_samp.size()-3];
      m_pend = seen_edge || (m_pend && !ack);
      if (!m_hand) begin
         if (exc) begin
            m_elr  = pc;
            m_esr  = es;
            m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
            m_hand = 1;
         end
      end else if (exc) begin
         m_esr = m_esr | 4'b1000;
      end else if (eret) begin
         m_hand = 0;
      end
      m_samp.push_back(irq);
      void'(m_samp.pop_front());
      #1;
   endtask

   task automatic idle(input bit irq);
      cycle(0, 4'b0000, 0, 0, irq, 64'h0);
   endtask

   initial begin
      reset = 1'b0; IrqRaw = 1'b1; Exc = 1'b1; EStatus = 4'b0010;
      ERet = 1'b0; ExtIAck = 1'b0; PC = 64'h40;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ExtIRQ", 64'(ExtIRQ), 64'd0);
      check("rst_ExcAck", 64'(ExcAck), 64'd0);
      check("rst_ExcRedirect", 64'(ExcRedirect), 64'd0);
      check("rst_ExcPC", ExcPC, VEC);
      check("rst_ELR", ELR, 64'd0);
      check("rst_ESR", 64'(ESR), 64'd0);
      check("rst_InHandler", 64'(InHandler), 64'd0);
      check("rst_ExcCount", 64'(ExcCount), 64'd0);
      Exc = 1'b0; IrqRaw = 1'b0;
      reset = 1'b1;
      idle(0); idle(0);

      // illegal opcode then return
      cycle(1, 4'b0010, 0, 0, 0, 64'h40);
      check("ill_ELR", ELR, 64'h40);
      check("ill_ESR", 64'(ESR), 64'd2);
      check("ill_InHandler", 64'(InHandler), 64'd1);
      check("ill_ExcCount", 64'(ExcCount), 64'd1);
      cycle(0, 4'b0000, 1, 0, 0, 64'h44);
      check("ret_InHandler", 64'(InHandler), 64'd0);

      // IRQ latency: three edges from IrqRaw rising to ExtIRQ
      idle(1); idle(1);
      check("irq_lat2", 64'(ExtIRQ), 64'd0);
      idle(1);
      check("irq_lat3", 64'(ExtIRQ), 64'd1);
      cycle(1, 4'b0001, 0, 1, 1, 64'h100);
      check("irq_ELR", ELR, 64'h100);
      check("irq_ESR", 64'(ESR), 64'd1);

      // second IRQ edge while in handler is held pending
      idle(0); idle(0); idle(0);
      idle(1); idle(1); idle(1); idle(1);
      check("irq_masked", 64'(ExtIRQ), 64'd0);

      // double fault
      cycle(1, 4'b0010, 1, 0, 1, 64'h200);
      check("df_ESR", 64'(ESR), 64'd9);
      check("df_ELR", ELR, 64'h100);
      check("df_ExcCount", 64'(ExcCount), 64'd2);
      check("df_InHandler", 64'(InHandler), 64'd1);
      cycle(0, 4'b0000, 1, 0, 1, 64'h204);
      check("irq_after_ret", 64'(ExtIRQ), 64'd1);
      cycle(0, 4'b0000, 0, 1, 1, 64'h0);
      check("irq_cleared", 64'(ExtIRQ), 64'd0);

      // ERet in RUN is ignored
      cycle(0, 4'b0000, 1, 0, 1, 64'h300);
      check("eret_run_InHandler", 64'(InHandler), 64'd0);

      // set and clear of pending in the same cycle: set wins
      idle(0); idle(0); idle(0);
      idle(1); idle(1);
      cycle(0, 4'b0000, 0, 1, 1, 64'h0);
      check("set_wins", 64'(ExtIRQ), 64'd1);
      cycle(0, 4'b0000, 0, 1, 1, 64'h0);

      // saturation
      for (int i = 0; i < 260; i++) begin
         cycle(1, 4'b0010, 0, 0, 1, 64'(i * 4));
         cycle(0, 4'b0000, 1, 0, 1, 64'h0);
      end
      check("sat_ExcCount", 64'(ExcCount), 64'd255);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bit irq_r;
         irq_r = ($urandom_range(0, 5) == 0) ? !m_samp[m_samp.size()-1] : m_samp[m_samp.size()-1];
         cycle($urandom_range(0, 7) == 0,
               ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'b0001,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               irq_r,
               {$urandom(), $urandom()});
      end

      // reset in the middle of a handler
      idle(1); idle(1); idle(1);
      cycle(1, 4'b0010, 0, 0, 1, 64'h500);
      Exc = 1'b0; ERet = 1'b0; ExtIAck = 1'b0; IrqRaw = 1'b0; PC = 64'h0;
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_InHandler", 64'(InHandler), 64'd0);
      check("mid_rst_ELR", ELR, 64'd0);
      check("mid_rst_ESR", 64'(ESR), 64'd0);
      check("mid_rst_ExcCount", 64'(ExcCount), 64'd0);
      check("mid_rst_ExtIRQ", 64'(ExtIRQ), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      idle(0); idle(0);
      cycle(1, 4'b0001, 0, 0, 0, 64'h600);
      check("post_rst_ExcCount", 64'(ExcCount), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
